// File: rtl/button_tick_debouncer_if.sv
// button_tick_debouncer_if: raw tick/button inputs and debounced pulse outputs of the debouncer
interface button_tick_debouncer_if #(
    parameter int N_BTN = 4
);
    logic             tick_in;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;
    logic             sample_tick;

    modport master (
        output tick_in, btn_raw,
        input  btn_level, btn_press, btn_release, btn_repeat, sample_tick
    );

    modport slave (
        input  tick_in, btn_raw,
        output btn_level, btn_press, btn_release, btn_repeat, sample_tick
    );
endinterface

// File: rtl/button_tick_debouncer.sv
// button_tick_debouncer: tick-strobed push-button debouncer with press/release/auto-repeat pulses
module button_tick_debouncer #(
    parameter int N_BTN        = 4,
    parameter int DEB_SAMPLES  = 3,
    parameter int REPEAT_DELAY = 25,
    parameter int REPEAT_RATE  = 5
) (
    input logic                    CLK,
    input logic                    reset,
    button_tick_debouncer_if.slave bus
);
    localparam int DEB_W   = $clog2(DEB_SAMPLES + 1);
    localparam int REP_MAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    typedef enum logic [1:0] {REL, HOLD, RPT} state_e;

    logic [1:0]       tick_sync_q;
    logic             tick_prev_q;
    logic             sample_tick_q;
    logic [N_BTN-1:0] btn_s1_q, btn_s2_q;
    logic [N_BTN-1:0] level_q, press_q, release_q, repeat_q;
    logic [N_BTN-1:0] flip, rise, fall, fire;
    logic [DEB_W-1:0] deb_cnt_q [N_BTN];
    logic [DEB_W-1:0] deb_cnt_d [N_BTN];
    logic [REP_W-1:0] rep_cnt_q [N_BTN];
    logic [REP_W-1:0] rep_cnt_d [N_BTN];
    state_e           state_q   [N_BTN];
    state_e           state_d   [N_BTN];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tick_sync_q   <= '0;
            tick_prev_q   <= 1'b0;
            sample_tick_q <= 1'b0;
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            level_q       <= '0;
            press_q       <= '0;
            release_q     <= '0;
            repeat_q      <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                deb_cnt_q[i] <= '0;
                rep_cnt_q[i] <= '0;
                state_q[i]   <= REL;
            end
        end else begin
            tick_sync_q   <= {tick_sync_q[0], bus.tick_in};
            tick_prev_q   <= tick_sync_q[1];
            sample_tick_q <= tick_sync_q[1] & ~tick_prev_q;
            btn_s1_q      <= bus.btn_raw;
            btn_s2_q      <= btn_s1_q;
            level_q       <= level_q ^ flip;
            press_q       <= rise;
            release_q     <= fall;
            repeat_q      <= fire;
            for (int i = 0; i < N_BTN; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                rep_cnt_q[i] <= rep_cnt_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end

    // Any agreeing sample restarts the run; a full run of disagreeing samples flips the level.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            flip[i] = sample_tick_q && btn_s2_q[i] != level_q[i] && int'(deb_cnt_q[i]) + 1 == DEB_SAMPLES;
            rise[i] = flip[i] & ~level_q[i];
            fall[i] = flip[i] & level_q[i];
            deb_cnt_d[i] = !sample_tick_q ? deb_cnt_q[i]
                         : (btn_s2_q[i] == level_q[i] || flip[i]) ? '0
                         : deb_cnt_q[i] + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]   = state_q[i];
            rep_cnt_d[i] = rep_cnt_q[i];
            if (fall[i]) begin
                state_d[i]   = REL;
                rep_cnt_d[i] = '0;
            end else if (rise[i]) begin
                state_d[i]   = HOLD;
                rep_cnt_d[i] = '0;
            end else if (fire[i]) begin
                state_d[i]   = RPT;
                rep_cnt_d[i] = '0;
            end else if (sample_tick_q && (state_q[i] == RPT || (state_q[i] == HOLD && REPEAT_DELAY != 0))) begin
                rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
        end
    end

    // A release tick suppresses any repeat that would otherwise fire on it.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            fire[i] = sample_tick_q && !fall[i] &&
                      ((state_q[i] == HOLD && REPEAT_DELAY != 0 && int'(rep_cnt_q[i]) == REPEAT_DELAY - 1) ||
                       (state_q[i] == RPT && int'(rep_cnt_q[i]) == REPEAT_RATE - 1));
        end
    end

    assign bus.sample_tick = sample_tick_q;
    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_repeat  = repeat_q;
endmodule

// File: tb/tb_button_tick_debouncer.sv
// tb_button_tick_debouncer: random and directed stimulus checked every cycle against a tick-level model
module tb_button_tick_debouncer;
    localparam int N = 4, DEB = 3, DLY = 25, RATE = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    button_tick_debouncer_if #(.N_BTN(N)) bif ();

    button_tick_debouncer #(
        .N_BTN(N), .DEB_SAMPLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
    ) dut (
        .CLK(clk),
        .reset(rst_n),
        .bus(bif)
    );

    int tests = 0, fails = 0;
    bit checking = 1'b0;
    int age = 99;
    bit valid = 1'b0;
    logic [N-1:0] m_level, p_press, p_rel, p_rep;
    int run [N];
    int held [N];
    logic [N-1:0] exp_level = '0, exp_press = '0, exp_rel = '0, exp_rep = '0;
    logic exp_st = 1'b0;
    int cyc = 0, tick_no = 0;
    int press_cnt [N], rep_cnt [N];
    int last_press_tick [N], last_rel_tick [N], last_rep_tick [N];
    int last_press_cyc [N], last_rel_cyc [N];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = '0;
        p_press = '0;
        p_rel   = '0;
        p_rep   = '0;
        valid   = 1'b0;
        for (int i = 0; i < N; i++) begin
            run[i]  = 0;
            held[i] = 0;
        end
    endtask

    // One strobe: run = disagreeing samples since last level change, held = ticks since press.
    task automatic model_sample(input logic [N-1:0] raw);
        p_press = '0;
        p_rel   = '0;
        p_rep   = '0;
        for (int i = 0; i < N; i++) begin
            run[i] = (raw[i] == m_level[i]) ? 0 : run[i] + 1;
            if (run[i] == DEB) begin
                m_level[i] = raw[i];
                run[i] = 0;
                if (raw[i]) begin
                    p_press[i] = 1'b1;
                    held[i] = 0;
                end else p_rel[i] = 1'b1;
            end else if (m_level[i]) begin
                held[i]++;
                if (DLY > 0 && held[i] >= DLY && (held[i] - DLY) % RATE == 0) p_rep[i] = 1'b1;
            end
        end
    endtask

    // One 16-CLK tick period; reset is asserted for phases [rst_lo, rst_hi).
    task automatic tick_period(input logic [N-1:0] raw, input bit glitch, input int rst_lo, input int rst_hi);
        for (int p = 0; p < 16; p++) begin
            @(posedge clk);
            #2;
            rst_n = !(p >= rst_lo && p < rst_hi);
            if (!rst_n) model_reset();
            if (p == 0) begin
                bif.tick_in = 1'b1;
                bif.btn_raw = raw;
                age = 0;
                valid = rst_n;
                if (rst_n) model_sample(raw);
            end else age++;
            if (p == 8) bif.tick_in = 1'b0;
            if (glitch && p >= 6 && p < 12) bif.btn_raw = N'($urandom);
            if (p == 12) bif.btn_raw = raw;
            exp_st    = valid && age == 3;
            exp_press = '0;
            exp_rel   = '0;
            exp_rep   = '0;
            if (!rst_n) exp_level = '0;
            else if (valid && age == 4) begin
                exp_level = m_level;
                exp_press = p_press;
                exp_rel   = p_rel;
                exp_rep   = p_rep;
            end
            if (rst_lo > 0 && p == rst_lo) begin
                #1;
                chk("reset_clears", int'({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat, bif.sample_tick}), 0);
            end
            checking = 1'b1;
        end
    endtask

    task automatic ticks(input logic [N-1:0] raw, input int n);
        for (int k = 0; k < n; k++) tick_period(raw, 1'b0, 99, 99);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cyc++;
            if (bif.sample_tick) tick_no++;
            for (int i = 0; i < N; i++) begin
                if (bif.btn_press[i]) begin
                    press_cnt[i]++;
                    last_press_tick[i] = tick_no;
                    last_press_cyc[i] = cyc;
                end
                if (bif.btn_release[i]) begin
                    last_rel_tick[i] = tick_no;
                    last_rel_cyc[i] = cyc;
                end
                if (bif.btn_repeat[i]) begin
                    rep_cnt[i]++;
                    last_rep_tick[i] = tick_no;
                end
            end
            chk("sample_tick", int'(bif.sample_tick), int'(exp_st));
            chk("btn_level", int'(bif.btn_level), int'(exp_level));
            chk("btn_press", int'(bif.btn_press), int'(exp_press));
            chk("btn_release", int'(bif.btn_release), int'(exp_rel));
            chk("btn_repeat", int'(bif.btn_repeat), int'(exp_rep));
        end
    end

    initial begin
        int t0, c0, r0;
        int bounce [6] = '{1, 1, 0, 1, 1, 1};
        logic [N-1:0] r;
        bif.tick_in = 1'b0;
        bif.btn_raw = '0;
        model_reset();
        #1 rst_n = 1'b0;

        repeat (3) tick_period(4'hF, 1'b0, 0, 16);
        tick_period(4'hF, 1'b0, 0, 10);
        t0 = tick_no;
        ticks(4'hF, 3);
        for (int i = 0; i < N; i++) chk("press_after_reset", last_press_tick[i], t0 + 3);
        ticks(4'h0, 3);

        t0 = tick_no;
        c0 = press_cnt[0];
        ticks(4'b0001, 4);
        chk("clean_press_tick", last_press_tick[0], t0 + 3);
        chk("clean_press_once", press_cnt[0] - c0, 1);

        t0 = tick_no;
        c0 = press_cnt[1];
        for (int k = 0; k < 6; k++) tick_period(bounce[k] != 0 ? 4'b0011 : 4'b0001, 1'b0, 99, 99);
        chk("bounce_press_tick", last_press_tick[1], t0 + 6);
        chk("bounce_press_once", press_cnt[1] - c0, 1);

        t0 = tick_no;
        r0 = rep_cnt[2];
        ticks(4'b0111, 48);
        chk("repeat_count", rep_cnt[2] - r0, 5);
        chk("repeat_last_tick", last_rep_tick[2], t0 + 48);
        ticks(4'b0011, 6);
        chk("release2_tick", last_rel_tick[2], t0 + 51);
        chk("no_repeat_after_release", rep_cnt[2] - r0, 5);

        t0 = tick_no;
        ticks(4'b1010, 3);
        chk("release0_tick", last_rel_tick[0], t0 + 3);
        chk("press3_tick", last_press_tick[3], t0 + 3);
        chk("same_cycle_rel_press", last_press_cyc[3], last_rel_cyc[0]);

        r0 = rep_cnt[2];
        ticks(4'b1110, 30);
        chk("in_rpt_before_reset", rep_cnt[2] - r0, 1);
        tick_period(4'b1110, 1'b0, 10, 12);
        t0 = tick_no;
        ticks(4'b1110, 3);
        chk("repress2_tick", last_press_tick[2], t0 + 3);
        chk("repress3_tick", last_press_tick[3], t0 + 3);

        r = 4'b1110;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 99) < (k < 250 ? 25 : 3)) r[i] = ~r[i];
            tick_period(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0) ? 10 : 99, 12);
        end
        ticks(r, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
